// File: rtl/video_reg_commit_pkg.sv
// Shared definitions for the vblank-synchronised video register commit block:
// register map indices, CTRL/status bit positions, FSM states, byte-merge helper.
package video_reg_commit_pkg;

  // Word index of the control/status register in the iomem window
  localparam logic [3:0] REG_CTRL = 4'd15;

  // CTRL write bits
  localparam int unsigned CTRL_AUTO_BIT    = 0;
  localparam int unsigned CTRL_PENDING_BIT = 1;
  localparam int unsigned CTRL_CLR_OVR_BIT = 2;

  // Commit FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } state_e;

  // Merge new bytes into an old word according to the byte strobes
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/video_reg_commit.sv
// Vblank-synchronised commit controller. CPU writes land in a shadow bank and
// mark dirty bits; on each vblank rise an FSM copies the dirty words into the
// live video register bank one word per cycle so no frame sees a torn update.
module video_reg_commit
  import video_reg_commit_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 10,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic        iomem_ready,
  output logic [31:0] iomem_rdata,
  input  logic        vblank,
  output logic        reg_we,
  output logic [3:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        commit_irq
);

  localparam int unsigned CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_REGS - 1);

  // State
  logic [31:0]            shadow_q [NUM_REGS];
  logic [NUM_REGS-1:0]    dirty_q;
  logic                   auto_q;
  logic                   pending_q;
  logic                   overrun_q;
  logic                   vblank_q;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   ready_q;
  logic [31:0]            rdata_q;
  logic                   reg_we_q;
  logic [3:0]             reg_addr_q;
  logic [31:0]            reg_wdata_q;
  logic                   irq_q;

  // Decode / next-state
  logic [3:0]          idx_d;
  logic                accept_d;
  logic                wr_d;
  logic                shadow_hit_d;
  logic                shadow_wr_d;
  logic                ctrl_wr_d;
  logic                vb_rise_d;
  logic                busy_d;
  logic                start_d;
  logic [15:0]         frame16_d;
  logic [31:0]         status_d;
  logic [31:0]         rdata_d;
  logic [NUM_REGS-1:0] dirty_d;
  logic                unused_addr_s;

  assign idx_d        = iomem_addr[5:2];
  assign accept_d     = iomem_valid & sel & ~ready_q;
  assign wr_d         = accept_d & (|iomem_wstrb);
  assign shadow_hit_d = (32'(idx_d) < NUM_REGS);
  assign shadow_wr_d  = wr_d & shadow_hit_d;
  assign ctrl_wr_d    = wr_d & (idx_d == REG_CTRL) & iomem_wstrb[0];
  assign vb_rise_d    = vblank & ~vblank_q;
  assign busy_d       = (state_q == ST_COPY);
  assign start_d      = vb_rise_d & (pending_q | (auto_q & (|dirty_q)));
  assign unused_addr_s = ^{iomem_addr[31:6], iomem_addr[1:0]};

  // Status frame counter field is always 16 bits wide
  if (FRAME_CNT_W >= 16) begin : g_fc_trunc
    assign frame16_d = frame_cnt_q[15:0];
  end else begin : g_fc_ext
    assign frame16_d = {{(16 - FRAME_CNT_W){1'b0}}, frame_cnt_q};
  end

  assign status_d = {frame16_d, 12'd0, overrun_q, busy_d, pending_q, auto_q};

  // Read mux: shadow words, CTRL status, zero elsewhere
  always_comb begin
    rdata_d = 32'd0;
    if (shadow_hit_d) begin
      rdata_d = shadow_q[idx_d];
    end else if (idx_d == REG_CTRL) begin
      rdata_d = status_d;
    end else begin
      rdata_d = 32'd0;
    end
  end

  // Dirty bits: copy clears the word in flight, a CPU write in the same cycle wins
  always_comb begin
    dirty_d = dirty_q;
    if (busy_d) begin
      dirty_d[cnt_q] = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
    if (shadow_wr_d) begin
      dirty_d[idx_d] = 1'b1;
    end else begin
      dirty_d = dirty_d;
    end
  end

  // Bus handshake, read data capture and shadow bank byte-merged writes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        shadow_q[i] <= 32'd0;
      end
    end else begin
      ready_q <= accept_d;
      if (accept_d) begin
        rdata_q <= rdata_d;
      end
      if (shadow_wr_d) begin
        shadow_q[idx_d] <= byte_merge(shadow_q[idx_d], iomem_wdata, iomem_wstrb);
      end
    end
  end

  // Vblank history for rise detection; tracks the pin even in reset so a high
  // vblank at reset release is not mistaken for a new frame
  always_ff @(posedge clk) begin
    vblank_q <= vblank;
  end

  // Commit FSM with CTRL/status state and registered live-bank outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      dirty_q     <= {NUM_REGS{1'b0}};
      auto_q      <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= {FRAME_CNT_W{1'b0}};
      reg_we_q    <= 1'b0;
      reg_addr_q  <= 4'd0;
      reg_wdata_q <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      irq_q    <= 1'b0;
      dirty_q  <= dirty_d;
      if (ctrl_wr_d) begin
        auto_q <= iomem_wdata[CTRL_AUTO_BIT];
        if (iomem_wdata[CTRL_CLR_OVR_BIT]) begin
          overrun_q <= 1'b0;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            state_q <= ST_COPY;
            cnt_q   <= {CNT_W{1'b0}};
          end
        end
        ST_COPY: begin
          reg_we_q    <= dirty_q[cnt_q];
          reg_addr_q  <= 4'(cnt_q);
          reg_wdata_q <= shadow_q[cnt_q];
          if (vb_rise_d) begin
            overrun_q <= 1'b1;
          end
          if (cnt_q == LAST_CNT) begin
            state_q     <= ST_IDLE;
            irq_q       <= 1'b1;
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            pending_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // A fresh commit request outranks the clear at the end of a commit
      if (ctrl_wr_d && iomem_wdata[CTRL_PENDING_BIT]) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign reg_we      = reg_we_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign commit_irq  = irq_q;

endmodule

// File: tb/tb_video_reg_commit.sv
// Self-checking bench for video_reg_commit: randomized register traffic and
// frames checked against a behavioural model of shadow/dirty/live banks.
module tb_video_reg_commit;

  localparam int NR = 10;

  logic        clk;
  logic        resetn;
  logic        sel;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic        vblank;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        commit_irq;

  int checks   = 0;
  int failures = 0;
  int we_total = 0;

  // Behavioural model
  logic [31:0] m_shadow [NR];
  bit          m_dirty  [NR];
  logic [31:0] m_live   [16];
  logic [31:0] live_mon [16];
  bit          m_auto, m_pending, m_ovr;
  logic [15:0] m_frame;

  video_reg_commit #(.NUM_REGS(10), .FRAME_CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .iomem_valid(iomem_valid),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata), .vblank(vblank),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .commit_irq(commit_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Live bank as seen by the video block
  always @(negedge clk) begin
    if (reg_we) begin
      live_mon[reg_addr] = reg_wdata;
      we_total++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status();
    return {m_frame, 12'd0, m_ovr, 1'b0, m_pending, m_auto};
  endfunction

  function automatic bit any_dirty();
    bit r = 1'b0;
    for (int i = 0; i < NR; i++) r |= m_dirty[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_shadow[i] = 32'd0; m_dirty[i] = 1'b0; end
    m_auto = 1'b0; m_pending = 1'b0; m_ovr = 1'b0; m_frame = 16'd0;
  endtask

  task automatic model_write(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s);
    if (int'(idx) < NR) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_shadow[idx][8*b +: 8] = d[8*b +: 8];
      m_dirty[idx] = 1'b1;
    end else if (idx == 4'd15 && s[0]) begin
      m_auto = d[0];
      if (d[1]) m_pending = 1'b1;
      if (d[2]) m_ovr = 1'b0;
    end
  endtask

  task automatic bus_xfer(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd);
    bit got = 1'b0;
    int lat = 0;
    rd = 32'd0;
    @(negedge clk);
    iomem_valid = 1'b1; sel = 1'b1; iomem_addr = {26'd0, idx, 2'b00};
    iomem_wdata = d; iomem_wstrb = s;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if (iomem_ready) begin got = 1'b1; lat = n; rd = iomem_rdata; end
    end
    iomem_valid = 1'b0; sel = 1'b0; iomem_wstrb = 4'd0;
    checks++;
    if (!got || lat != 1) begin
      failures++;
      $display("FAIL bus_ready_latency idx=%0d: got=%0d latency=%0d, required latency 1", idx, got, lat);
    end
    @(negedge clk);
    checks++;
    if (iomem_ready !== 1'b0) begin
      failures++;
      $display("FAIL bus_ready_pulse idx=%0d: ready=%b on second cycle, required 0", idx, iomem_ready);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bus_xfer(idx, d, s, rd);
    model_write(idx, d, s);
  endtask

  task automatic check_read(input string nm, input logic [3:0] idx, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(idx, 32'd0, 4'd0, rd);
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d: read 0x%08h, required 0x%08h", nm, idx, rd, exp);
    end
  endtask

  task automatic check_live(input string nm);
    bit ok = 1'b1;
    for (int i = 0; i < 16; i++) if (live_mon[i] !== m_live[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s live_bank: word0=0x%08h word4=0x%08h, required word0=0x%08h word4=0x%08h",
               nm, live_mon[0], live_mon[4], m_live[0], m_live[4]);
    end
  endtask

  // One vblank frame; optional CPU write landing during the copy and optional vblank re-rise
  task automatic do_frame(input string nm, input bit inj_en, input int inj_cyc,
                          input logic [3:0] inj_idx, input logic [31:0] inj_data, input bit ovr_en);
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    int          got_cyc[$];
    bit          trig;
    int          irq_n = 0;
    int          irq_cyc = -1;
    int          slot;
    int          nmin;
    trig = m_pending || (m_auto && any_dirty());
    slot = inj_cyc - 1;
    if (trig) begin
      for (int k = 0; k < NR; k++) begin
        if (m_dirty[k]) begin
          exp_q.push_back({4'(k), m_shadow[k]});
          m_live[k]  = m_shadow[k];
          m_dirty[k] = 1'b0;
        end
        if (inj_en && k == slot) model_write(inj_idx, inj_data, 4'hF);
      end
      m_frame++;
      m_pending = 1'b0;
      if (ovr_en) m_ovr = 1'b1;
    end else if (inj_en) begin
      model_write(inj_idx, inj_data, 4'hF);
    end

    @(negedge clk);
    vblank = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (reg_we) begin got_q.push_back({reg_addr, reg_wdata}); got_cyc.push_back(i); end
      if (commit_irq) begin irq_n++; irq_cyc = i; end
      if (inj_en && i == inj_cyc + 1) begin
        checks++;
        if (iomem_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s inj_ready: ready=%b, required 1", nm, iomem_ready);
        end
        iomem_valid = 1'b0; sel = 1'b0; iomem_wstrb = 4'd0;
      end
      if (inj_en && i == inj_cyc) begin
        iomem_valid = 1'b1; sel = 1'b1; iomem_addr = {26'd0, inj_idx, 2'b00};
        iomem_wdata = inj_data; iomem_wstrb = 4'hF;
      end
      if (ovr_en && i == 3) vblank = 1'b0;
      if (ovr_en && i == 4) vblank = 1'b1;
    end
    vblank = 1'b0;

    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s we_count: %0d live writes, required %0d", nm, got_q.size(), exp_q.size());
    end
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] != int'(exp_q[i][35:32]) + 2) begin
        failures++;
        $display("FAIL %s we_entry%0d: addr=%0d data=0x%08h cyc=%0d, required addr=%0d data=0x%08h cyc=%0d",
                 nm, i, got_q[i][35:32], got_q[i][31:0], got_cyc[i],
                 exp_q[i][35:32], exp_q[i][31:0], int'(exp_q[i][35:32]) + 2);
      end
    end
    checks++;
    if (irq_n != (trig ? 1 : 0) || (trig && irq_cyc != NR + 1)) begin
      failures++;
      $display("FAIL %s irq: count=%0d cycle=%0d, required count=%0d cycle=%0d",
               nm, irq_n, irq_cyc, trig ? 1 : 0, NR + 1);
    end
    check_live(nm);
    check_read({nm, "_status"}, 4'd15, exp_status());
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (iomem_ready !== 1'b0 || reg_we !== 1'b0 || commit_irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b we=%b irq=%b, required 0 0 0", iomem_ready, reg_we, commit_irq);
    end
    check_read("reset_status", 4'd15, 32'd0);
    check_read("reset_shadow0", 4'd0, 32'd0);
  endtask

  task automatic test_write_read();
    bit seen = 1'b0;
    @(negedge clk);
    iomem_valid = 1'b1; sel = 1'b0; iomem_addr = 32'd0; iomem_wdata = 32'hDEAD_BEEF; iomem_wstrb = 4'hF;
    repeat (3) begin @(negedge clk); if (iomem_ready) seen = 1'b1; end
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL unselected_ready: ready seen=1, required 0");
    end
    wr(4'd0, 32'h0000_0012, 4'b0001);
    repeat (3) @(negedge clk);
    checks++;
    if (we_total != 0) begin
      failures++;
      $display("FAIL no_vblank_we: %0d live writes, required 0", we_total);
    end
    check_read("write_idx0", 4'd0, 32'h0000_0012);
    wr(4'd0, 32'hFFFF_3400, 4'b0010);
    check_read("byte_merge_idx0", 4'd0, m_shadow[0]);
    wr(4'd12, 32'h1234_5678, 4'hF);
    check_read("unmapped_idx12", 4'd12, 32'd0);
  endtask

  task automatic test_auto_commit();
    wr(4'd15, 32'h1, 4'hF);
    wr(4'd1, 32'h34, 4'hF);
    wr(4'd3, 32'h0420_0010, 4'hF);
    do_frame("auto_commit", 1'b0, 0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++)
        wr(4'($urandom_range(0, 14)), $urandom, 4'($urandom_range(1, 15)));
      if ($urandom_range(0, 2) == 0) wr(4'd15, {31'd0, 1'($urandom_range(0, 1))}, 4'hF);
      do_frame("random_frame", 1'b0, 0, 4'd0, 32'd0, 1'b0);
    end
    for (int i = 0; i < NR; i++) check_read("readback", 4'(i), m_shadow[i]);
  endtask

  task automatic test_copy_race();
    wr(4'd15, 32'h1, 4'hF);
    for (int k = 0; k < NR; k++) wr(4'(k), $urandom, 4'hF);
    do_frame("race_same", 1'b1, 5, 4'd4, 32'h0000_00AA, 1'b0);
    do_frame("race_same_next", 1'b0, 0, 4'd0, 32'd0, 1'b0);
    for (int k = 0; k < NR; k++) wr(4'(k), $urandom, 4'hF);
    do_frame("race_ahead", 1'b1, 3, 4'd7, $urandom, 1'b0);
    for (int k = 0; k < NR; k++) wr(4'(k), $urandom, 4'hF);
    do_frame("race_behind", 1'b1, 7, 4'd1, $urandom, 1'b0);
    do_frame("race_behind_next", 1'b0, 0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic test_overrun();
    wr(4'd2, $urandom, 4'hF);
    do_frame("overrun", 1'b0, 0, 4'd0, 32'd0, 1'b1);
    wr(4'd15, 32'h5, 4'hF);
    check_read("overrun_clear", 4'd15, exp_status());
  endtask

  task automatic test_pending();
    wr(4'd15, 32'h2, 4'hF);
    do_frame("pending_flush", 1'b0, 0, 4'd0, 32'd0, 1'b0);
    wr(4'd15, 32'h2, 4'hF);
    do_frame("pending_empty", 1'b0, 0, 4'd0, 32'd0, 1'b0);
    wr(4'd6, $urandom, 4'hF);
    do_frame("no_auto_no_pending", 1'b0, 0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_mid_copy();
    wr(4'd15, 32'h1, 4'hF);
    for (int k = 0; k < NR; k++) wr(4'(k), $urandom, 4'hF);
    m_live[0] = m_shadow[0];
    m_live[1] = m_shadow[1];
    @(negedge clk);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (reg_we !== 1'b0 || commit_irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_copy_we: we=%b irq=%b, required 0 0", reg_we, commit_irq);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    check_live("reset_mid_copy");
    vblank = 1'b0;
    check_read("reset_mid_status", 4'd15, 32'd0);
    check_read("reset_mid_shadow5", 4'd5, 32'd0);
    wr(4'd15, 32'h1, 4'hF);
    do_frame("post_reset_clean", 1'b0, 0, 4'd0, 32'd0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; sel = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    iomem_addr = 32'd0; iomem_wdata = 32'd0; vblank = 1'b0;
    for (int i = 0; i < 16; i++) begin m_live[i] = 32'd0; live_mon[i] = 32'd0; end
    model_reset();
    test_reset();
    test_write_read();
    test_auto_commit();
    test_random_frames();
    test_copy_race();
    test_overrun();
    test_pending();
    test_reset_mid_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
